sliding_window_ctrl: RTL

SLIDING_WINDOW_CTRL -- requirements
Module: sliding_window_ctrl

---
 rtl/sliding_window_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sliding_window_ctrl.sv
// ============================================================================
// Module      : sliding_window_ctrl
// Description : Scans a packed int8 frame in 4-pixel column blocks, feeding a
//               4-row window buffer and presenting each complete 4x4 window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sliding_window_ctrl #(
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rd_data,
   output logic              sw_valid_in,
   output logic [31:0]       sw_pixels,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [7:0]        win_row,
   output logic [7:0]        win_col
);

   localparam int C_WPR = IMG_W / 4;
   localparam int C_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int C_CB_W = (C_WPR > 1) ? $clog2(C_WPR) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_LOAD    = 3'd2,
      S_PRESENT = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t               state_q;
   logic [ADDR_W-1:0]    base_q;
   logic [C_CB_W-1:0]    cb_q;
   logic [C_ROW_W-1:0]   row_q;
   logic [2:0]           fill_q;
   logic [2:0]           fill_d;
   logic                 w_last_row;
   logic                 w_last_cb;
   logic                 w_run;
   logic [ADDR_W-1:0]    w_rd_addr;

   assign fill_d     = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
   assign w_last_row = (row_q == C_ROW_W'(IMG_H - 1));
   assign w_last_cb  = (cb_q == C_CB_W'(C_WPR - 1));
   assign w_rd_addr  = base_q + ADDR_W'(row_q) * ADDR_W'(C_WPR) + ADDR_W'(cb_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         cb_q    <= '0;
         row_q   <= '0;
         fill_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  base_q  <= base_addr;
                  cb_q    <= '0;
                  row_q   <= '0;
                  fill_q  <= '0;
                  state_q <= S_READ;
               end
            end
            S_READ: state_q <= S_LOAD;
            S_LOAD: begin
               fill_q <= fill_d;
               if (fill_d == 3'd4) begin
                  state_q <= S_PRESENT;
               end else begin
                  row_q   <= row_q + 1'b1;
                  state_q <= S_READ;
               end
            end
            S_PRESENT: begin
               if (win_ready) begin
                  if (!w_last_row) begin
                     row_q   <= row_q + 1'b1;
                     state_q <= S_READ;
                  end else if (!w_last_cb) begin
                     // New column block: the four refill rows flush the stale buffer
                     cb_q    <= cb_q + 1'b1;
                     row_q   <= '0;
                     fill_q  <= '0;
                     state_q <= S_READ;
                  end else begin
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Outputs decode the registered state and are forced low during reset
   assign w_run       = !reset;
   assign busy        = w_run && ((state_q == S_READ) || (state_q == S_LOAD) ||
                                  (state_q == S_PRESENT));
   assign done        = w_run && (state_q == S_DONE);
   assign mem_rd_en   = w_run && (state_q == S_READ);
   assign mem_addr    = mem_rd_en ? w_rd_addr : '0;
   assign sw_valid_in = w_run && (state_q == S_LOAD);
   assign sw_pixels   = sw_valid_in ? mem_rd_data : '0;
   assign win_valid   = w_run && (state_q == S_PRESENT);
   assign win_row     = win_valid ? (8'(row_q) - 8'd3) : '0;
   assign win_col     = win_valid ? 8'({cb_q, 2'b00}) : '0;

endmodule

`default_nettype wire
